// File: rtl/sdram_arbit.sv
// SDRAM command arbiter: init owns the pins until flag_init_end, then refresh > write > read.
// Define SDRAM_ARB_RR_EN to resolve simultaneous write/read requests round-robin.
module sdram_arbit #(
  parameter int         REF_CNT_END = 780,
  parameter logic [3:0] NOP_CMD     = 4'b0111
) (
  input  logic        sclk,
  input  logic        rstn,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [11:0] init_addr,
  input  logic        ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [11:0] ref_addr,
  input  logic        wr_req,
  input  logic        wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [1:0]  wr_bank,
  input  logic [11:0] wr_addr,
  input  logic        rd_req,
  input  logic        rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [1:0]  rd_bank,
  input  logic [11:0] rd_addr,
  output logic        ref_en,
  output logic        wr_en,
  output logic        rd_en,
  output logic [3:0]  sdram_cmd,
  output logic [1:0]  sdram_bank,
  output logic [11:0] sdram_addr
);

  localparam int CNT_W = $clog2(REF_CNT_END);

  typedef enum logic [2:0] {IDLE, ARBIT, AREF, WRITE, READ} state_t;

  state_t           state;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_req;
  logic             ref_wrap;
  logic             pick_wr;

  assign ref_wrap = flag_init_end && (ref_cnt == CNT_W'(REF_CNT_END - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      ref_cnt <= '0;
    end else if (!flag_init_end || ref_wrap) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + CNT_W'(1);
    end
  end

  // A wrap landing on the same edge as the grant keeps the request alive.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      ref_req <= 1'b0;
    end else if (ref_wrap) begin
      ref_req <= 1'b1;
    end else if (state == ARBIT && ref_req) begin
      ref_req <= 1'b0;
    end
  end

`ifdef SDRAM_ARB_RR_EN
  // Remembers which side won the last write/read tie; reset value favours write next.
  logic last_grant_wr;
  assign pick_wr = wr_req && (!rd_req || !last_grant_wr);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      last_grant_wr <= 1'b0;
    end else if (state == ARBIT && !ref_req && wr_req && rd_req) begin
      last_grant_wr <= pick_wr;
    end
  end
`else
  assign pick_wr = wr_req;
`endif

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      ref_en <= 1'b0;
      wr_en  <= 1'b0;
      rd_en  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (flag_init_end) state <= ARBIT;
        end
        ARBIT: begin
          if (ref_req) begin
            state  <= AREF;
            ref_en <= 1'b1;
          end else if (pick_wr) begin
            state <= WRITE;
            wr_en <= 1'b1;
          end else if (rd_req) begin
            state <= READ;
            rd_en <= 1'b1;
          end
        end
        AREF: begin
          if (ref_end) begin
            state  <= ARBIT;
            ref_en <= 1'b0;
          end
        end
        WRITE: begin
          if (wr_end) begin
            state <= ARBIT;
            wr_en <= 1'b0;
          end
        end
        READ: begin
          if (rd_end) begin
            state <= ARBIT;
            rd_en <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          ref_en <= 1'b0;
          wr_en  <= 1'b0;
          rd_en  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    sdram_cmd  = NOP_CMD;
    sdram_bank = 2'b00;
    sdram_addr = '0;
    case (state)
      IDLE: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        sdram_cmd  = ref_cmd;
        sdram_addr = ref_addr;
      end
      WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_bank = wr_bank;
        sdram_addr = wr_addr;
      end
      READ: begin
        sdram_cmd  = rd_cmd;
        sdram_bank = rd_bank;
        sdram_addr = rd_addr;
      end
      default: ;
    endcase
  end

endmodule
